// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE exception flags and small index-width helpers.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Width of an index into n items; never zero so N=1 still has a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpnew_rr_arbiter.sv
// Combinational round-robin pick over N requesters plus the rotating priority pointer.
module fpnew_rr_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned N  = 5,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [0:N-1]  req_i,
  input  logic          ack_i,
  output logic [0:N-1]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  // Scan ptr, ptr+1, ... mod N; the first requester found wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr_q) + i) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (found) gnt_o[idx_o] = 1'b1;
  end

  // Priority rotates past the winner only when its transfer is accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (ack_i) ptr_d = IW'((32'(idx_o) + 1) % N);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fpnew_opgroup_out_arbiter.sv
// Merges the per-format slice result streams of one opgroup into a single
// registered output stream using round-robin arbitration.
module fpnew_opgroup_out_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumFormats = 5,
  parameter int unsigned Width      = 64,
  parameter type         TagType    = logic
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [0:NumFormats-1][Width-1:0]     res_i,
  input  status_t [0:NumFormats-1]             status_i,
  input  logic [0:NumFormats-1]                ext_bit_i,
  input  TagType [0:NumFormats-1]              tag_i,
  input  logic [0:NumFormats-1]                in_valid_i,
  output logic [0:NumFormats-1]                in_ready_o,
  input  logic                                 flush_i,
  output logic [Width-1:0]                     result_o,
  output status_t                              status_o,
  output logic                                 extension_bit_o,
  output TagType                               tag_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 busy_o
);

  localparam int unsigned IW = idx_width(NumFormats);

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high; valid never depends on ready, and a raised valid with its payload
  // stays stable until that transfer (both on the input and output side).

  logic [0:NumFormats-1] gnt;
  logic [IW-1:0]         win_idx;
  logic                  any_valid;
  logic                  load_en;
  logic                  transfer;

  logic                  valid_q;
  logic [Width-1:0]      result_q;
  status_t               status_q;
  logic                  ext_q;
  TagType                tag_q;

  assign any_valid = |in_valid_i;
  assign load_en   = !valid_q | out_ready_i;
  // Flush and reset both block acceptance so nothing is lost silently.
  assign transfer  = any_valid & load_en & ~flush_i & rst_ni;
  assign in_ready_o = transfer ? gnt : '0;

  fpnew_rr_arbiter #(
    .N (NumFormats)
  ) u_rr_arbiter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (in_valid_i),
    .ack_i  (transfer),
    .gnt_o  (gnt),
    .idx_o  (win_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      status_q <= '0;
      ext_q    <= 1'b0;
      tag_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (transfer) begin
      valid_q  <= 1'b1;
      result_q <= res_i[win_idx];
      status_q <= status_i[win_idx];
      ext_q    <= ext_bit_i[win_idx];
      tag_q    <= tag_i[win_idx];
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o     = valid_q;
  assign busy_o          = valid_q;
  assign result_o        = result_q;
  assign status_o        = status_q;
  assign extension_bit_o = ext_q;
  assign tag_o           = tag_q;

endmodule

// File: tb/tb_fpnew_opgroup_out_arbiter.sv
// Directed and random stimulus for the opgroup output arbiter with a
// round-robin reference model and an expected-result queue.
module tb_fpnew_opgroup_out_arbiter;
  import fpnew_pkg::*;

  localparam int N = 5;
  localparam int W = 64;
  typedef logic [3:0] tag_t;

  // clock / reset
  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [0:N-1][W-1:0] res_i;
  status_t [0:N-1]     status_i;
  logic [0:N-1]        ext_bit_i;
  tag_t [0:N-1]        tag_i;
  logic [0:N-1]        in_valid_i;
  logic [0:N-1]        in_ready_o;
  logic                flush_i;
  logic [W-1:0]        result_o;
  status_t             status_o;
  logic                extension_bit_o;
  tag_t                tag_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic                busy_o;

  fpnew_opgroup_out_arbiter #(
    .NumFormats (N),
    .Width      (W),
    .TagType    (tag_t)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .res_i           (res_i),
    .status_i        (status_i),
    .ext_bit_i       (ext_bit_i),
    .tag_i           (tag_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .flush_i         (flush_i),
    .result_o        (result_o),
    .status_o        (status_o),
    .extension_bit_o (extension_bit_o),
    .tag_o           (tag_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .busy_o          (busy_o)
  );

  // scoreboard and reference model state
  logic [73:0] exp_q[$];
  int          gnt_log[$];
  int          exp_log[$];
  bit          m_valid;
  int          m_ptr;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [0:N-1] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic check_log(input string tag);
    for (int i = 0; i < exp_log.size(); i++) begin
      check(tag, (i < gnt_log.size()) ? gnt_log[i] : -99, exp_log[i]);
    end
  endtask

  // One clock: check combinational and registered outputs against the model,
  // update scoreboard, advance to just after the next rising edge.
  task automatic step();
    int          w;
    int          obs_g;
    logic [0:N-1] exp_rdy;
    #1;
    w = pick(in_valid_i, m_ptr);
    exp_rdy = '0;
    if ((!m_valid || out_ready_i) && !flush_i && w >= 0) exp_rdy[w] = 1'b1;
    check("in_ready", in_ready_o, exp_rdy);
    check("out_valid", out_valid_o, m_valid);
    check("busy", busy_o, m_valid);
    if (m_valid) begin
      if (exp_q.size() == 0) check("queue_empty", 1, 0);
      else begin
        check("out_data", {result_o, tag_o, status_o, extension_bit_o}, exp_q[0]);
        if (out_ready_i || flush_i) void'(exp_q.pop_front());
      end
    end
    obs_g = -1;
    for (int i = 0; i < N; i++) if (in_ready_o[i]) obs_g = i;
    gnt_log.push_back(obs_g);
    if (exp_rdy != '0) begin
      exp_q.push_back({res_i[w], tag_i[w], status_i[w], ext_bit_i[w]});
      m_ptr   = (w + 1) % N;
      m_valid = 1'b1;
    end else if (flush_i || out_ready_i) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    for (int k = 0; k < N; k++) begin
      res_i[k]     = W'(k + 100);
      tag_i[k]     = tag_t'(k);
      status_i[k]  = '0;
      ext_bit_i[k] = 1'b0;
    end
  endtask

  initial begin
    set_defaults();
    in_valid_i  = '1;
    out_ready_i = 1'b1;
    flush_i     = 1'b0;
    m_valid     = 1'b0;
    m_ptr       = 0;

    // reset held with all inputs valid
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_status", status_o, 0);
    rst_ni = 1'b1;

    // round robin with all inputs valid, no bubbles
    gnt_log.delete();
    repeat (6) step();
    exp_log = '{0, 1, 2, 3, 4, 0};
    check_log("rr_order");
    in_valid_i = '0;
    step();
    step();

    // skip: move pointer to 2, then only inputs 1 and 3 valid, idle gap
    in_valid_i[1] = 1'b1;
    step();
    in_valid_i = '0;
    step();
    gnt_log.delete();
    in_valid_i[1] = 1'b1;
    in_valid_i[3] = 1'b1;
    step();
    in_valid_i = '0;
    step();
    step();
    in_valid_i[1] = 1'b1;
    in_valid_i[3] = 1'b1;
    step();
    step();
    exp_log = '{3, -1, -1, 1, 3};
    check_log("skip_order");
    in_valid_i = '0;
    step();

    // backpressure: entry from input 2 held for 10 cycles
    out_ready_i   = 1'b0;
    in_valid_i[2] = 1'b1;
    step();
    in_valid_i[0] = 1'b1;
    gnt_log.delete();
    repeat (10) step();
    exp_log = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    check_log("bp_no_ready");
    check("bp_result", result_o, 102);
    check("bp_tag", tag_o, 2);
    out_ready_i = 1'b1;
    gnt_log.delete();
    step();
    exp_log = '{0};
    check_log("bp_release");
    in_valid_i = '0;
    step();

    // flush with tag 7 buffered while input 0 requests
    out_ready_i   = 1'b0;
    tag_i[2]      = 4'd7;
    in_valid_i[2] = 1'b1;
    step();
    check("flush_tag_held", tag_o, 7);
    in_valid_i    = '0;
    in_valid_i[0] = 1'b1;
    flush_i       = 1'b1;
    gnt_log.delete();
    step();
    flush_i = 1'b0;
    check("flush_valid", out_valid_o, 0);
    check("flush_busy", busy_o, 0);
    step();
    exp_log = '{-1, 0};
    check_log("flush_order");
    out_ready_i = 1'b1;
    in_valid_i  = '0;
    step();
    tag_i[2] = 4'd2;

    // status and extension bit travel with their result
    status_i[4]   = 5'b00001;
    ext_bit_i[4]  = 1'b1;
    res_i[4]      = 64'hdead;
    in_valid_i[4] = 1'b1;
    step();
    in_valid_i = '0;
    check("st_status", status_o, 5'b00001);
    check("st_ext", extension_bit_o, 1);
    check("st_result", result_o, 64'hdead);
    step();
    set_defaults();

    // random traffic with backpressure and occasional flush
    repeat (60) begin
      in_valid_i  = N'($urandom);
      out_ready_i = 1'($urandom_range(0, 1));
      flush_i     = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < N; k++) begin
        res_i[k]     = {$urandom, $urandom};
        status_i[k]  = status_t'($urandom_range(0, 31));
        ext_bit_i[k] = 1'($urandom_range(0, 1));
        tag_i[k]     = tag_t'($urandom_range(0, 15));
      end
      step();
    end
    flush_i = 1'b0;
    set_defaults();

    // reset while an entry is held
    out_ready_i   = 1'b0;
    in_valid_i    = '0;
    in_valid_i[1] = 1'b1;
    step();
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_result", result_o, 0);
    check("mid_rst_ready", in_ready_o, 0);
    m_valid = 1'b0;
    m_ptr   = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_ni      = 1'b1;
    in_valid_i  = '1;
    out_ready_i = 1'b1;
    gnt_log.delete();
    step();
    exp_log = '{0};
    check_log("post_rst_grant");
    in_valid_i = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpnew_opgroup_out_arbiter.md
Name: fpnew_opgroup_out_arbiter

Overview:
Downstream neighbour of the per-format operation-group slices. Collects the result streams of NumFormats format slices belonging to one opgroup and arbitrates them round-robin into a single registered output stream. The output stream feeds the FPU top-level result arbitration. Provides a one-entry output buffer with full-throughput valid/ready handshake, flush, and busy indication.

Parameters:
NumFormats, 5, number of format-slice inputs (N ≥ 1).
Width, 64, result width in bits.
TagType, logic, type of the operation tag carried alongside results.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
res_i  in  [0:N-1][Width-1:0]  per-slice result
status_i  in  [0:N-1] fpnew_pkg::status_t  per-slice status flags {NV,DZ,OF,UF,NX}
ext_bit_i  in  [0:N-1]  per-slice extension bit
tag_i  in  [0:N-1] TagType  per-slice tag
in_valid_i  in  [0:N-1]  per-slice result valid
in_ready_o  out  [0:N-1]  per-slice ready; at most one bit high per cycle
flush_i  in  1  drop the buffered result
result_o  out  Width  buffered result
status_o  out  status_t  buffered status
extension_bit_o  out  1  buffered extension bit
tag_o  out  TagType  buffered tag
out_valid_o  out  1  buffered entry valid
out_ready_i  in  1  downstream ready
busy_o  out  1  entry held (equals out_valid_o)

Behaviour:
- Reset (async, rst_ni=0): out_valid_o=0; result_o='0; status_o='0; extension_bit_o=0; tag_o='0; RR pointer=0. in_ready_o is combinational and therefore 0 while no entry can load.
- load_en = !out_valid_o | out_ready_i (the entry is empty or drains this cycle).
- Arbitration is combinational. Scan indices ptr, ptr+1, … mod N. The first index with in_valid_i high is the winner k.
- in_ready_o[k] = load_en & any_valid. All other ready bits are 0.
- Transfer on input k: in_valid_i[k] & in_ready_o[k]. On the next edge the entry captures res_i[k], status_i[k], ext_bit_i[k], tag_i[k], sets out_valid_o=1, and sets ptr = (k+1) mod N.
- Drain without new load: out_valid_o & out_ready_i with no input transfer → out_valid_o=0. Data registers hold their values.
- Simultaneous drain and load: the entry is replaced in the same edge. Sustained throughput is 1 result/cycle.
- Latency: input handshake at cycle t → out_valid_o high from t+1.
- Backpressure: out_valid_o=1 & out_ready_i=0 → all in_ready_o=0. Outputs must stay stable until accepted.
- flush_i (priority over everything): next edge out_valid_o=0. in_ready_o is forced to 0 during the flush cycle, so nothing is accepted. ptr is unchanged. Data registers are unchanged.
- Pointer moves only on an accepted transfer. An idle cycle does not change the pointer.
- N=1: pointer is constant 0, and the block degenerates to a pipeline register.
- Reset mid-operation: the held entry is lost and all outputs return to their reset values immediately.
- Input valids are not required to be stable while unselected. The arbiter makes no fairness guarantee for inputs that withdraw valid.

Decomposition:
- fpnew_pkg: reuses status_t. Add a helper function clog2-safe idx_width(N) = (N>1)?$clog2(N):1.
- Sub-module fpnew_rr_arbiter holds the combinational round-robin pick and the pointer register. Ports: clk_i, rst_ni, req_i, ack_i, gnt_o, idx_o.
- The output register lives in this top module.

Test Plan:
1. Reset: hold rst_ni=0, then drive in_valid_i=5'b11111 → out_valid_o=0, result_o=0, in_ready_o=0. After release with out_ready_i=1, the first grant goes to index 0.
2. Round-robin: all 5 inputs valid continuously, out_ready_i=1 → accepted order 0,1,2,3,4,0. res_i[k]=k+100 appears on result_o one cycle after each grant, with no bubbles.
3. Skip: only inputs 1 and 3 valid, ptr=2 → 3 granted, then 1, then 3. The pointer does not move on idle cycles.
4. Backpressure: hold out_ready_i=0 with input 2 transferred → out_valid_o=1, result and tag stable, all in_ready_o=0 for 10 cycles. Raising out_ready_i drains and accepts the next input in the same cycle.
5. Flush: entry valid with tag=7, flush_i=1 while input 0 is valid → in_ready_o=0. Next cycle out_valid_o=0 and busy_o=0, and input 0 is accepted one cycle later.
6. Status/ext: input 4 drives status=5'b00001 and ext_bit=1 → status_o=5'b00001 and extension_bit_o=1, appearing exactly with the corresponding result.
